// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs toward the controller and the
// four pipeline-register stall/flush controls back to the pipeline.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ID_rs1_i;
    logic [REG_AW-1:0] ID_rs2_i;
    logic              ID_rs1_used_i;
    logic              ID_rs2_used_i;
    logic              ID_EX_read_mem_i;
    logic [REG_AW-1:0] ID_EX_rd_i;
    logic              EX_pc_load_i;
    logic              MEM_busy_i;
    logic              IF_ID_stall_o;
    logic              IF_ID_flush_o;
    logic              ID_EX_stall_o;
    logic              ID_EX_flush_o;

    modport master (
        output ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               ID_EX_read_mem_i, ID_EX_rd_i, EX_pc_load_i, MEM_busy_i,
        input  IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o, ID_EX_flush_o
    );

    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               ID_EX_read_mem_i, ID_EX_rd_i, EX_pc_load_i, MEM_busy_i,
        output IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o, ID_EX_flush_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, post-branch flush, memory-wait freeze.
// Optional perf counters (stall_cnt_o/flush_cnt_o) exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W       = 32
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int MAX_CNT = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] LU_INIT    = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic           hit;
    logic           if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;

    assign rs1 = hz.ID_rs1_i;
    assign rs2 = hz.ID_rs2_i;
    assign rd  = hz.ID_EX_rd_i;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign hit = hz.ID_EX_read_mem_i && (rd != '0) &&
                 ((hz.ID_rs1_used_i && (rs1 == rd)) ||
                  (hz.ID_rs2_used_i && (rs2 == rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        if (hz.MEM_busy_i) begin
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (hz.EX_pc_load_i) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    id_ex_flush = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                // The load has already left EX, so hit is deliberately ignored here.
                LU_WAIT: begin
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    if (hit) begin
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LU_WAIT;
                            cnt_d   = LU_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign hz.IF_ID_stall_o = reset_n & if_id_stall;
    assign hz.IF_ID_flush_o = reset_n & if_id_flush;
    assign hz.ID_EX_stall_o = reset_n & id_ex_stall;
    assign hz.ID_EX_flush_o = reset_n & id_ex_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic             stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Outside busy, IF_ID_stall only comes from load-use; ID_EX_flush without it is control flush.
    assign stall_inc = if_id_stall && !hz.MEM_busy_i;
    assign flush_inc = id_ex_flush && !if_id_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3, both
// FLUSH_DEPTH=2) receive identical stimulus; expected output vectors come from tables.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) if_a ();
    hazard_ctrl_if #(.REG_AW(5)) if_b ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(2)) u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (if_a)
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cnt_o (stall_cnt_a),
        .flush_cnt_o (flush_cnt_a)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(2)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (if_b)
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cnt_o (stall_cnt_b),
        .flush_cnt_o (flush_cnt_b)
`endif
    );

    // Output vector order: {IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush}
    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_LU   = 4'b1001;
    localparam logic [3:0] E_PCL  = 4'b0101;
    localparam logic [3:0] E_FL   = 4'b0001;
    localparam logic [3:0] E_BUSY = 4'b1010;

    localparam int K_IDLE = 0, K_HIT = 1, K_PCL = 2, K_BUSY = 3, K_HITPCL = 4,
                   K_BUSYPCL = 5, K_RD0 = 6, K_RS2UNUSED = 7, K_RS2HIT = 8, K_NOLOAD = 9;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       rm;
        logic [4:0] rd;
        logic       pcl;
        logic       busy;
        logic [3:0] ea;
        logic [3:0] eb;
    } stim_t;

    logic [3:0] obs_a, obs_b;
    assign obs_a = {if_a.IF_ID_stall_o, if_a.IF_ID_flush_o, if_a.ID_EX_stall_o, if_a.ID_EX_flush_o};
    assign obs_b = {if_b.IF_ID_stall_o, if_b.IF_ID_flush_o, if_b.ID_EX_stall_o, if_b.ID_EX_flush_o};

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic stim_t mk(input int kind, input logic [3:0] ea, input logic [3:0] eb);
        stim_t s;
        s = '0;
        s.ea = ea;
        s.eb = eb;
        case (kind)
            K_HIT:       begin s.rs1 = 5; s.u1 = 1; s.rs2 = 7; s.u2 = 1; s.rm = 1; s.rd = 5; end
            K_PCL:       begin s.pcl = 1; end
            K_BUSY:      begin s.busy = 1; end
            K_HITPCL:    begin s.rs1 = 5; s.u1 = 1; s.rs2 = 7; s.u2 = 1; s.rm = 1; s.rd = 5; s.pcl = 1; end
            K_BUSYPCL:   begin s.busy = 1; s.pcl = 1; end
            K_RD0:       begin s.rs1 = 0; s.u1 = 1; s.rs2 = 0; s.u2 = 1; s.rm = 1; s.rd = 0; end
            K_RS2UNUSED: begin s.rs1 = 3; s.u1 = 1; s.rs2 = 5; s.u2 = 0; s.rm = 1; s.rd = 5; end
            K_RS2HIT:    begin s.rs1 = 3; s.u1 = 1; s.rs2 = 5; s.u2 = 1; s.rm = 1; s.rd = 5; end
            K_NOLOAD:    begin s.rs1 = 5; s.u1 = 1; s.rs2 = 5; s.u2 = 1; s.rm = 0; s.rd = 5; end
            default:     begin s.rs1 = 1; s.u1 = 1; s.rs2 = 2; s.u2 = 1; s.rm = 0; s.rd = 9; end
        endcase
        return s;
    endfunction

    // Drive both instances and record the expected response on the scoreboard.
    task automatic apply(input stim_t s);
        if_a.ID_rs1_i = s.rs1;      if_b.ID_rs1_i = s.rs1;
        if_a.ID_rs2_i = s.rs2;      if_b.ID_rs2_i = s.rs2;
        if_a.ID_rs1_used_i = s.u1;  if_b.ID_rs1_used_i = s.u1;
        if_a.ID_rs2_used_i = s.u2;  if_b.ID_rs2_used_i = s.u2;
        if_a.ID_EX_read_mem_i = s.rm; if_b.ID_EX_read_mem_i = s.rm;
        if_a.ID_EX_rd_i = s.rd;     if_b.ID_EX_rd_i = s.rd;
        if_a.EX_pc_load_i = s.pcl;  if_b.EX_pc_load_i = s.pcl;
        if_a.MEM_busy_i = s.busy;   if_b.MEM_busy_i = s.busy;
        exp_q.push_back({s.ea, s.eb});
    endtask

    task automatic test_reset();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_HITPCL, E_NONE, E_NONE), mk(K_BUSY, E_NONE, E_NONE)};
        reset_n = 1'b0;
        @(posedge clk); #1;
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL reset[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL reset[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("reset[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_HIT, E_LU, E_LU), mk(K_IDLE, E_NONE, E_LU), mk(K_IDLE, E_NONE, E_LU),
               mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL load_use[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL load_use[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("load_use[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_hazard();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_RD0, E_NONE, E_NONE), mk(K_RS2UNUSED, E_NONE, E_NONE), mk(K_NOLOAD, E_NONE, E_NONE),
               mk(K_RS2HIT, E_LU, E_LU), mk(K_IDLE, E_NONE, E_LU), mk(K_IDLE, E_NONE, E_LU),
               mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL no_hazard[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL no_hazard[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("no_hazard[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_flush();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_PCL, E_PCL, E_PCL), mk(K_IDLE, E_FL, E_FL), mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL branch[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL branch[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("branch[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_HITPCL, E_PCL, E_PCL), mk(K_IDLE, E_FL, E_FL), mk(K_IDLE, E_NONE, E_NONE),
               mk(K_HIT, E_LU, E_LU), mk(K_PCL, E_PCL, E_PCL), mk(K_IDLE, E_FL, E_FL),
               mk(K_IDLE, E_NONE, E_NONE), mk(K_BUSYPCL, E_BUSY, E_BUSY), mk(K_IDLE, E_NONE, E_NONE),
               mk(K_PCL, E_PCL, E_PCL), mk(K_HIT, E_FL, E_FL), mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL priority[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL priority[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("priority[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_busy();
        stim_t st[$];
        logic [7:0] e;
        st = '{mk(K_PCL, E_PCL, E_PCL), mk(K_BUSY, E_BUSY, E_BUSY), mk(K_BUSY, E_BUSY, E_BUSY),
               mk(K_BUSY, E_BUSY, E_BUSY), mk(K_BUSY, E_BUSY, E_BUSY), mk(K_IDLE, E_FL, E_FL),
               mk(K_IDLE, E_NONE, E_NONE), mk(K_HIT, E_LU, E_LU), mk(K_BUSY, E_BUSY, E_BUSY),
               mk(K_IDLE, E_NONE, E_LU), mk(K_IDLE, E_NONE, E_LU), mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL mem_busy[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL mem_busy[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("mem_busy[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [7:0] e;
        apply(mk(K_HIT, E_LU, E_LU));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_a !== e[7:4]) begin n_err++; $display("FAIL rst_mid enter A: got %b want %b", obs_a, e[7:4]); end
        n_cmp++;
        if (obs_b !== e[3:0]) begin n_err++; $display("FAIL rst_mid enter B: got %b want %b", obs_b, e[3:0]); end
        $display("rst_mid enter: A=%b B=%b", obs_a, obs_b);
        @(posedge clk); #1;
        // Instance B is now in LU_WAIT; drop reset between clock edges.
        apply(mk(K_HITPCL, E_NONE, E_NONE));
        #1 reset_n = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_a !== e[7:4]) begin n_err++; $display("FAIL rst_mid async A: got %b want %b", obs_a, e[7:4]); end
        n_cmp++;
        if (obs_b !== e[3:0]) begin n_err++; $display("FAIL rst_mid async B: got %b want %b", obs_b, e[3:0]); end
        $display("rst_mid async: A=%b B=%b", obs_a, obs_b);
        @(posedge clk); #1;
        reset_n = 1'b1;
        apply(mk(K_IDLE, E_NONE, E_NONE));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_a !== e[7:4]) begin n_err++; $display("FAIL rst_mid after A: got %b want %b", obs_a, e[7:4]); end
        n_cmp++;
        if (obs_b !== e[3:0]) begin n_err++; $display("FAIL rst_mid after B: got %b want %b", obs_b, e[3:0]); end
        $display("rst_mid after: A=%b B=%b", obs_a, obs_b);
        @(posedge clk); #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        stim_t st[$];
        logic [7:0] e;
        n_cmp++;
        if (stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0) begin
            n_err++; $display("FAIL perf after reset A: got %0d/%0d want 0/0", stall_cnt_a, flush_cnt_a);
        end
        st = '{mk(K_HIT, E_LU, E_LU), mk(K_IDLE, E_NONE, E_LU), mk(K_PCL, E_PCL, E_PCL),
               mk(K_IDLE, E_FL, E_FL), mk(K_IDLE, E_NONE, E_NONE)};
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_a !== e[7:4]) begin n_err++; $display("FAIL perf[%0d] A: got %b want %b", i, obs_a, e[7:4]); end
            n_cmp++;
            if (obs_b !== e[3:0]) begin n_err++; $display("FAIL perf[%0d] B: got %b want %b", i, obs_b, e[3:0]); end
            $display("perf[%0d]: A=%b B=%b", i, obs_a, obs_b);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stall_cnt_a !== 32'd1) begin n_err++; $display("FAIL perf stall_cnt A: got %0d want 1", stall_cnt_a); end
        n_cmp++;
        if (flush_cnt_a !== 32'd2) begin n_err++; $display("FAIL perf flush_cnt A: got %0d want 2", flush_cnt_a); end
        n_cmp++;
        if (stall_cnt_b !== 32'd2) begin n_err++; $display("FAIL perf stall_cnt B: got %0d want 2", stall_cnt_b); end
        n_cmp++;
        if (flush_cnt_b !== 32'd2) begin n_err++; $display("FAIL perf flush_cnt B: got %0d want 2", flush_cnt_b); end
        $display("perf counters: A=%0d/%0d B=%0d/%0d", stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b);
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_flush();
        test_priority();
        test_mem_busy();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard residue: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
